// File: rtl/lift_step_seq.sv
// lift_step_seq: 5/3 lifting-step sequencer driving the ram_r pixel RAMs.
// Sweeps idx 0..len-1 and reads left/right/odd at each index. It writes the
// predict or update result back to the odd RAM at the same index.
// Optional macro LIFT_SAT_EN saturates the result to the signed DW range
// instead of wrapping.
module lift_step_seq #(
  parameter int AW = 7,
  parameter int DW = 26
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [AW:0]   len,
  output logic [AW-1:0] pix_addr_l,
  output logic [AW-1:0] pix_addr_r,
  output logic [AW-1:0] pix_addr_odd,
  input  logic [DW-1:0] pix_dout_l,
  input  logic [DW-1:0] pix_dout_r,
  input  logic [DW-1:0] pix_dout_odd,
  output logic [DW-1:0] pix_din_odd,
  output logic          pix_we_odd,
  output logic [DW-1:0] pix_din_l,
  output logic [DW-1:0] pix_din_r,
  output logic          pix_we_l,
  output logic          pix_we_r,
  output logic          busy,
  output logic          done
);
  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, FIN} state_t;
  localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};
  localparam logic signed [DW+1:0] SAT_MAX = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [DW+1:0] SAT_MIN = {3'b111, {(DW-1){1'b0}}};
  state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0] len_q, len_d;
  logic mode_q, mode_d, busy_q, busy_d, done_q, done_d, we_q, we_d;
  logic signed [DW-1:0] l_s, r_s, o_s, res;
  logic signed [DW:0] s;
  logic signed [DW+1:0] res_w;
  // Lifting arithmetic on the RAM read data; only consumed while in WR.
  always_comb begin
    l_s = pix_dout_l;
    r_s = pix_dout_r;
    o_s = pix_dout_odd;
    s = (DW+1)'(l_s) + (DW+1)'(r_s);
    res_w = mode_q ? (DW+2)'(o_s) + (((DW+2)'(s) + (DW+2)'(2)) >>> 2)
                   : (DW+2)'(o_s) - (DW+2)'(s >>> 1);
`ifdef LIFT_SAT_EN
    res = (res_w > SAT_MAX) ? DW'(SAT_MAX) : (res_w < SAT_MIN) ? DW'(SAT_MIN) : DW'(res_w);
`else
    res = DW'(res_w);
`endif
  end
  // Next-state logic for the sweep FSM; len is clamped to 2**AW when latched.
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    len_d = len_q;
    mode_d = mode_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        mode_d = mode;
        len_d = (len > LEN_MAX) ? LEN_MAX : len;
        idx_d = '0;
        busy_d = 1'b1;
        state_d = (len == '0) ? FIN : RD;
      end
      RD: state_d = WAIT;
      WAIT: state_d = WR;
      WR: begin
        state_d = ({1'b0, idx_q} == len_q - (AW+1)'(1)) ? FIN : RD;
        idx_d = (state_d == RD) ? idx_q + AW'(1) : idx_q;
      end
      FIN: begin
        state_d = IDLE;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    we_d = (state_d == WR);
  end
  // State and registered outputs; reset abandons any sweep in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      len_q <= '0;
      mode_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      len_q <= len_d;
      mode_q <= mode_d;
      busy_q <= busy_d;
      done_q <= done_d;
      we_q <= we_d;
    end
  end
  assign pix_addr_l = idx_q;
  assign pix_addr_r = idx_q;
  assign pix_addr_odd = idx_q;
  assign pix_din_odd = (state_q == WR) ? res : '0;
  assign pix_we_odd = we_q;
  assign pix_din_l = '0;
  assign pix_din_r = '0;
  assign pix_we_l = 1'b0;
  assign pix_we_r = 1'b0;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_lift_step_seq.sv
// tb_lift_step_seq: scoreboard bench for lift_step_seq with a behavioural pixel RAM.
module tb_lift_step_seq;
  localparam int AW = 7;
  localparam int DW = 26;
  localparam longint SMAX = (longint'(1) << (DW-1)) - 1;
  localparam longint SMIN = -(longint'(1) << (DW-1));
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
  logic [AW:0] len = '0;
  logic [AW-1:0] pix_addr_l, pix_addr_r, pix_addr_odd;
  logic [DW-1:0] rd_l = '0, rd_r = '0, rd_odd = '0;
  logic [DW-1:0] pix_din_odd, pix_din_l, pix_din_r;
  logic pix_we_odd, pix_we_l, pix_we_r, busy, done;
  logic [DW-1:0] ram_l [0:127];
  logic [DW-1:0] ram_r [0:127];
  logic [DW-1:0] ram_odd [0:127];
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];
  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] saved;

  lift_step_seq #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .len(len),
    .pix_addr_l(pix_addr_l), .pix_addr_r(pix_addr_r), .pix_addr_odd(pix_addr_odd),
    .pix_dout_l(rd_l), .pix_dout_r(rd_r), .pix_dout_odd(rd_odd),
    .pix_din_odd(pix_din_odd), .pix_we_odd(pix_we_odd),
    .pix_din_l(pix_din_l), .pix_din_r(pix_din_r),
    .pix_we_l(pix_we_l), .pix_we_r(pix_we_r),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_l <= ram_l[pix_addr_l];
    rd_r <= ram_r[pix_addr_r];
    rd_odd <= ram_odd[pix_addr_odd];
    if (pix_we_odd) ram_odd[pix_addr_odd] <= pix_din_odd;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic m, input logic [DW-1:0] l, input logic [DW-1:0] r, input logic [DW-1:0] o);
    longint s, ov, res;
    s = longint'($signed(l)) + longint'($signed(r));
    ov = longint'($signed(o));
    res = m ? ov + ((s + 2) >>> 2) : ov - (s >>> 1);
`ifdef LIFT_SAT_EN
    if (res > SMAX) res = SMAX;
    if (res < SMIN) res = SMIN;
`endif
    return res[DW-1:0];
  endfunction

  always @(negedge clk) begin
    if (pix_we_odd) begin
      if (exp_addr.size() == 0) chk("spurious_we", 1, 0);
      else begin
        chk("wr_addr", 64'(pix_addr_odd), 64'(exp_addr.pop_front()));
        chk("wr_data", 64'(pix_din_odd), 64'(exp_data.pop_front()));
      end
    end
    if (pix_we_l || pix_we_r) chk("we_lr", {pix_we_l, pix_we_r}, 0);
  end

  task automatic sweep(input logic m, input logic [AW:0] n, input bit noise);
    int eff, k;
    eff = (n > 128) ? 128 : int'(n);
    for (int i = 0; i < eff; i++) begin
      exp_addr.push_back(AW'(i));
      exp_data.push_back(model(m, ram_l[i], ram_r[i], ram_odd[i]));
    end
    @(negedge clk);
    start = 1'b1; mode = m; len = n;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_on", busy, 1);
    k = 0;
    while (!done && k < 500) begin
      @(posedge clk);
      #1 k++;
      if (noise) begin
        start = (k == 50 || k == 200);
        len = 5;
      end
    end
    start = 1'b0;
    chk("done_lat", k, 3 * eff + 1);
    chk("busy_off", busy, 0);
    @(posedge clk);
    #1 chk("done_pulse", done, 0);
    repeat (5) @(posedge clk);
    chk("sb_drain", exp_addr.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      ram_l[i] = '0; ram_r[i] = '0; ram_odd[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", {pix_we_odd, pix_we_l, pix_we_r}, 0);
    chk("rst_addr", {pix_addr_l, pix_addr_r, pix_addr_odd}, 0);
    chk("rst_din", {pix_din_odd, pix_din_l, pix_din_r}, 0);
    @(negedge clk) rst_n = 1'b1;

    ram_l[0] = 10; ram_r[0] = 20; ram_odd[0] = 100;
    sweep(1'b0, 1, 0);
    chk("predict_basic", ram_odd[0], 85);
    ram_odd[0] = 100;
    sweep(1'b1, 1, 0);
    chk("update_basic", ram_odd[0], 108);
    ram_l[0] = -26'sd3; ram_r[0] = -26'sd4; ram_odd[0] = 0;
    sweep(1'b0, 1, 0);
    chk("predict_floor", ram_odd[0], 4);
    ram_l[0] = 2; ram_r[0] = 2; ram_odd[0] = 26'h1FFFFFF;
    sweep(1'b1, 1, 0);
`ifdef LIFT_SAT_EN
    chk("update_edge", ram_odd[0], 26'h1FFFFFF);
`else
    chk("update_edge", ram_odd[0], 26'h2000000);
`endif
    sweep(1'b0, 0, 0);

    for (int i = 0; i < 128; i++) begin
      ram_l[i] = DW'(i); ram_r[i] = DW'(i); ram_odd[i] = DW'(2 * i);
    end
    sweep(1'b0, 128, 1);
    chk("full_first", ram_odd[0], 0);
    chk("full_mid", ram_odd[77], 77);
    chk("full_last", ram_odd[127], 127);

    for (int i = 0; i < 128; i++) begin
      ram_l[i] = DW'($urandom); ram_r[i] = DW'($urandom); ram_odd[i] = DW'($urandom);
    end
    sweep(1'b1, 20, 0);
    sweep(1'b0, 200, 0);

    for (int i = 0; i < 5; i++) begin
      exp_addr.push_back(AW'(i));
      exp_data.push_back(model(1'b0, ram_l[i], ram_r[i], ram_odd[i]));
    end
    saved = ram_odd[5];
    @(negedge clk);
    start = 1'b1; mode = 1'b0; len = 10;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (16) @(posedge clk);
    #2 chk("wait_addr5", pix_addr_odd, 5);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_we", pix_we_odd, 0);
    chk("arst_addr", {pix_addr_l, pix_addr_r, pix_addr_odd}, 0);
    chk("arst_din", pix_din_odd, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ram5", ram_odd[5], saved);
    chk("post_rst_sb", exp_addr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
